cc_cond_unit: RTL

- Condition-code register and branch/move condition evaluator for the SEQ execute stage.
- Sits directly downstream of the ALU and captures its 3-bit new_cc flags on OPq instructions.
- Produces Cnd for jXX and cmovXX, evaluated combinationally from the committed CC of the current instruction.
- Cnd feeds the PC-update stage (jXX) and the write-back destination select (cmovXX).

---
 rtl/cc_cond_unit.sv | 69 ++++++
 1 files changed

// File: rtl/cc_cond_unit.sv
// Condition-code register and jXX/cmovXX condition evaluator for the SEQ execute stage.
// CC captures ALU flags on OPq; cnd is evaluated from the committed (pre-update) CC.
module cc_cond_unit #(
  parameter logic [2:0] CC_RESET = 3'b100,
  parameter logic [3:0] IOPQ     = 4'h6,
  parameter logic [3:0] IJXX     = 4'h7,
  parameter logic [3:0] IRRMOVQ  = 4'h2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] icode,
  input  logic [3:0] ifun,
  input  logic [2:0] new_cc,
  input  logic       stall,
  input  logic       suppress,
  output logic [2:0] cc,
  output logic       cnd,
  output logic       cnd_err
);

  logic [2:0] cc_q;
  logic [2:0] cc_d;
  logic       zf;
  logic       sf;
  logic       of;
  logic       lt;
  logic       is_cond;

  // new_cc is only looked at on a committed OPq, so junk flags elsewhere never reach cc_q
  always_comb begin
    cc_d = cc_q;
    if (!stall && !suppress && (icode == IOPQ)) begin
      cc_d = new_cc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cc_q <= CC_RESET;
    end else begin
      cc_q <= cc_d;
    end
  end

  assign cc      = cc_q;
  assign zf      = cc_q[2];
  assign sf      = cc_q[1];
  assign of      = cc_q[0];
  assign lt      = sf ^ of;
  assign is_cond = (icode == IJXX) || (icode == IRRMOVQ);

  always_comb begin
    cnd     = 1'b0;
    cnd_err = 1'b0;
    if (is_cond) begin
      case (ifun)
        4'd0:    cnd = 1'b1;
        4'd1:    cnd = lt | zf;
        4'd2:    cnd = lt;
        4'd3:    cnd = zf;
        4'd4:    cnd = ~zf;
        4'd5:    cnd = ~lt;
        4'd6:    cnd = ~lt & ~zf;
        default: cnd_err = 1'b1;
      endcase
    end
  end

endmodule
